// File: rtl/exu_muldiv_if.sv
// exu_muldiv_if: issue channel from IDU and result channel to LSU.
// master = IDU/LSU side, slave = execute unit.
interface exu_muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [3:0]      aluctr;
    logic            aluasrc;
    logic [1:0]      alubsrc;
    logic            md_en;
    logic [2:0]      md_op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] res;

    modport master (
        output in_valid, src1, src2, pc, imm,
        output aluctr, aluasrc, alubsrc,
        output md_en, md_op, out_ready,
        input  in_ready, out_valid, res
    );

    modport slave (
        input  in_valid, src1, src2, pc, imm,
        input  aluctr, aluasrc, alubsrc,
        input  md_en, md_op, out_ready,
        output in_ready, out_valid, res
    );
endinterface

// File: rtl/exu_muldiv.sv
// exu_muldiv: single-cycle ALU plus iterative radix-2 RV-M engine.
// One op in flight; result is registered and held until consumed.
module exu_muldiv #(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst,
    exu_muldiv_if.slave io
);
    localparam int SH = $clog2(XLEN);
    localparam int CW = SH + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] dvs;
    logic [2:0]      op_q;
    logic            neg_q;
    logic            accept;
    logic            md_last;

    // ALU
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sra_r;
    logic            lt;

    always_comb begin
        a = io.aluasrc ? io.pc : io.src1;
        unique case (io.alubsrc)
            2'b00: b = io.src2;
            2'b01: b = io.imm;
            2'b10: b = XLEN'(4);
            2'b11: b = '0;
        endcase
    end

    assign sra_r = $signed(a) >>> b[SH-1:0];
    assign lt = io.aluctr[3] ? (a < b)
                             : ($signed(a) < $signed(b));

    always_comb begin
        alu = '0;
        unique case (io.aluctr[2:0])
            3'b000: alu = io.aluctr[3] ? a - b : a + b;
            3'b001: alu = a << b[SH-1:0];
            3'b010: alu = {{(XLEN-1){1'b0}}, lt};
            3'b011: alu = b;
            3'b100: alu = a ^ b;
            3'b101: alu = io.aluctr[3] ? sra_r
                                       : a >> b[SH-1:0];
            3'b110: alu = a | b;
            3'b111: alu = a & b;
        endcase
    end

    // M-op setup: the engine works on magnitudes, sign fixed at the end
    logic            a_sgn;
    logic            b_sgn;
    logic            sa;
    logic            sb;
    logic            neg_st;
    logic [XLEN-1:0] ma;
    logic [XLEN-1:0] mb;

    always_comb begin
        a_sgn = io.md_op[2] ? !io.md_op[0]
                            : (io.md_op[1:0] != 2'b11);
        b_sgn = io.md_op[2] ? !io.md_op[0] : !io.md_op[1];
        sa = a_sgn & io.src1[XLEN-1];
        sb = b_sgn & io.src2[XLEN-1];
        ma = sa ? -io.src1 : io.src1;
        mb = sb ? -io.src2 : io.src2;
        // x/0 keeps an all-ones quotient, so no sign flip then
        if (!io.md_op[2])
            neg_st = sa ^ sb;
        else if (io.md_op[1])
            neg_st = sa;
        else
            neg_st = (sa ^ sb) & (|io.src2);
    end

    // one radix-2 step: shift-add multiply or restoring divide
    logic [XLEN:0]     sum;
    logic [XLEN:0]     shv;
    logic [XLEN:0]     diff;
    logic              ge;
    logic [XLEN-1:0]   hi_nxt;
    logic [XLEN-1:0]   lo_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   qr;
    logic [XLEN-1:0]   md_res;

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        shv  = {hi, lo[XLEN-1]};
        diff = shv - {1'b0, dvs};
        ge   = !diff[XLEN];
        if (op_q[2]) begin
            hi_nxt = ge ? diff[XLEN-1:0] : shv[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ge};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = neg_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
        qr   = op_q[1] ? hi_nxt : lo_nxt;
        if (op_q[2])
            md_res = neg_q ? -qr : qr;
        else if (op_q[1:0] == 2'b00)
            md_res = prod[XLEN-1:0];
        else
            md_res = prod[2*XLEN-1:XLEN];
    end

    // control FSM
    assign accept  = io.in_valid & io.in_ready;
    assign md_last = (state == BUSY) && (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = io.md_en ? BUSY : DONE;
            end
            BUSY: begin
                if (md_last)
                    state_nxt = DONE;
            end
            DONE: begin
                if (accept)
                    state_nxt = io.md_en ? BUSY : DONE;
                else if (io.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        unique case (state)
            IDLE: io.in_ready = 1'b1;
            BUSY: io.in_ready = 1'b0;
            DONE: begin
                io.in_ready  = io.out_ready;
                io.out_valid = 1'b1;
            end
            default: io.in_ready = 1'b0;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            res_q <= '0;
            hi    <= '0;
            lo    <= '0;
            dvs   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
        end else if (accept) begin
            if (io.md_en) begin
                cnt   <= CW'(XLEN);
                op_q  <= io.md_op;
                neg_q <= neg_st;
                hi    <= '0;
                lo    <= io.md_op[2] ? ma : mb;
                dvs   <= io.md_op[2] ? mb : ma;
            end else begin
                res_q <= alu;
            end
        end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            if (md_last)
                res_q <= md_res;
        end
    end

    assign io.res = res_q;
endmodule

// File: tb/tb_exu_muldiv.sv
// tb_exu_muldiv: directed vectors, expected results queued at issue,
// checked by an independent negedge monitor.
module tb_exu_muldiv;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    exu_muldiv_if #(.XLEN(32)) io32 ();
    exu_muldiv_if #(.XLEN(64)) io64 ();

    exu_muldiv #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .io (io32)
    );

    exu_muldiv #(.XLEN(64)) dut64 (
        .clk(clk),
        .rst(rst),
        .io (io64)
    );

    typedef struct {
        logic [31:0] val;
        int          lat;
        int          acc;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t drv_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_issued = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // monitor
    logic        holding = 1'b0;
    logic [31:0] held;

    initial forever begin
        @(negedge clk);
        #2;
        if (rst) begin
            holding = 1'b0;
        end else if (io32.out_valid) begin
            if (!holding) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected: res %h want none",
                             io32.res);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("res#%0d", mon_e.idx),
                          64'(io32.res), 64'(mon_e.val));
                    check($sformatf("lat#%0d", mon_e.idx),
                          64'(cyc - mon_e.acc), 64'(mon_e.lat));
                end
                held    = io32.res;
                holding = 1'b1;
            end else begin
                check("hold", 64'(io32.res), 64'(held));
            end
            if (io32.out_ready)
                holding = 1'b0;
        end
    end

    task automatic issue(input logic        md,
                         input logic [2:0]  mop,
                         input logic [3:0]  ctr,
                         input logic        asrc,
                         input logic [1:0]  bsrc,
                         input logic [31:0] s1,
                         input logic [31:0] s2,
                         input logic [31:0] p,
                         input logic [31:0] im,
                         input logic [31:0] want,
                         input logic        rel,
                         output int         waits);
        @(negedge clk);
        io32.md_en    = md;
        io32.md_op    = mop;
        io32.aluctr   = ctr;
        io32.aluasrc  = asrc;
        io32.alubsrc  = bsrc;
        io32.src1     = s1;
        io32.src2     = s2;
        io32.pc       = p;
        io32.imm      = im;
        io32.in_valid = 1'b1;
        if (rel)
            io32.out_ready = 1'b1;
        waits = 0;
        #4;
        while (!io32.in_ready && waits < 100) begin
            @(negedge clk);
            #4;
            waits++;
        end
        if (!io32.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept timeout: op %0d not taken",
                     n_issued);
        end else begin
            drv_e.val = want;
            drv_e.lat = md ? 33 : 1;
            drv_e.acc = cyc;
            drv_e.idx = n_issued;
            exp_q.push_back(drv_e);
        end
        n_issued++;
        @(posedge clk);
        #1;
        io32.in_valid = 1'b0;
        io32.src1     = $urandom();
        io32.src2     = $urandom();
        io32.aluctr   = 4'($urandom());
        io32.md_op    = 3'($urandom());
    endtask

    task automatic alu(input logic [3:0]  ctr,
                       input logic        asrc,
                       input logic [1:0]  bsrc,
                       input logic [31:0] s1,
                       input logic [31:0] s2,
                       input logic [31:0] p,
                       input logic [31:0] im,
                       input logic [31:0] want);
        int w;
        issue(1'b0, 3'b000, ctr, asrc, bsrc,
              s1, s2, p, im, want, 1'b0, w);
    endtask

    task automatic md(input logic [2:0]  op,
                      input logic [31:0] s1,
                      input logic [31:0] s2,
                      input logic [31:0] want);
        int w;
        issue(1'b1, op, 4'hF, 1'b1, 2'b01,
              s1, s2, 32'h1234, 32'h55, want, 1'b0, w);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d pending want 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    int          w;
    int          a64;
    int          n64;
    logic [31:0] bp_val;

    initial begin
        rst = 1'b1;
        io32.in_valid  = 1'b0;
        io32.out_ready = 1'b1;
        io32.src1      = '0;
        io32.src2      = '0;
        io32.pc        = '0;
        io32.imm       = '0;
        io32.aluctr    = '0;
        io32.aluasrc   = 1'b0;
        io32.alubsrc   = '0;
        io32.md_en     = 1'b0;
        io32.md_op     = '0;
        io64.in_valid  = 1'b0;
        io64.out_ready = 1'b1;
        io64.src1      = '0;
        io64.src2      = '0;
        io64.pc        = '0;
        io64.imm       = '0;
        io64.aluctr    = '0;
        io64.aluasrc   = 1'b0;
        io64.alubsrc   = '0;
        io64.md_en     = 1'b0;
        io64.md_op     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(io32.in_ready), 64'd1);
        check("rst_out_valid", 64'(io32.out_valid), 64'd0);
        check("rst_res", 64'(io32.res), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(io32.in_ready), 64'd1);

        // ALU sweep
        alu(4'b1000, 0, 2'b00, 5, 7, 0, 0, 32'hFFFF_FFFE);
        alu(4'b1101, 0, 2'b01, 32'h8000_0000, 0, 0, 4,
            32'hF800_0000);
        alu(4'b1010, 0, 2'b00, 1, 32'hFFFF_FFFF, 0, 0, 32'd1);
        alu(4'b0000, 1, 2'b10, 32'h77, 32'h99, 32'h8000_0000, 0,
            32'h8000_0004);
        alu(4'b0001, 0, 2'b00, 1, 32'h3F, 0, 0, 32'h8000_0000);
        alu(4'b0010, 0, 2'b00, 32'hFFFF_FFFF, 1, 0, 0, 32'd1);
        alu(4'b0101, 0, 2'b00, 32'h8000_0000, 4, 0, 0,
            32'h0800_0000);
        alu(4'b0100, 0, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0,
            32'hFF00_FF00);
        alu(4'b0110, 0, 2'b00, 32'hF0F0_F0F0, 32'h0F0F_0000, 0, 0,
            32'hFFFF_F0F0);
        alu(4'b0111, 0, 2'b00, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 0, 0,
            32'h3030_3030);
        alu(4'b0011, 0, 2'b11, 32'h1, 32'h5, 0, 0, 32'd0);
        alu(4'b0011, 0, 2'b01, 32'h1, 32'h5, 0, 32'hDEAD_BEEF,
            32'hDEAD_BEEF);
        drain();

        // multiply
        md(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        md(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        md(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        md(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);

        // divide and corners
        md(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        md(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        md(3'b101, 32'd123, 32'd0, 32'hFFFF_FFFF);
        md(3'b110, 32'd9, 32'd0, 32'd9);
        md(3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        md(3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
        md(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        md(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        md(3'b101, 32'd100, 32'd7, 32'd14);
        md(3'b111, 32'd100, 32'd7, 32'd2);
        drain();

        // reset in the middle of a divide
        md(3'b101, 32'd100, 32'd7, 32'd14);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("abort_in_ready", 64'(io32.in_ready), 64'd1);
        check("abort_out_valid", 64'(io32.out_valid), 64'd0);
        repeat (40) @(negedge clk);
        check("abort_quiet", 64'(io32.out_valid), 64'd0);

        // backpressure then same-cycle release
        @(negedge clk);
        io32.out_ready = 1'b0;
        bp_val = 32'd7;
        alu(4'b0000, 0, 2'b00, 3, 4, 0, 0, bp_val);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            check("bp_valid", 64'(io32.out_valid), 64'd1);
            check("bp_in_ready", 64'(io32.in_ready), 64'd0);
            check("bp_res", 64'(io32.res), 64'(bp_val));
        end
        issue(1'b0, 3'b000, 4'b1000, 0, 2'b00, 32'd10, 32'd3,
              0, 0, 32'd7 + 32'd0, 1'b1, w);
        check("release_waits", 64'(w), 64'd0);
        drain();

        // back-to-back ALU ops
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, 3'b000, 4'b0000, 0, 2'b01, 32'(i * 3),
                  0, 0, 32'd100, 32'(i * 3 + 100), 1'b0, w);
            check("b2b_waits", 64'(w), 64'd0);
        end
        drain();

        // XLEN=64 latency and result
        @(negedge clk);
        io64.md_en    = 1'b1;
        io64.md_op    = 3'b011;
        io64.src1     = '1;
        io64.src2     = 64'd2;
        io64.in_valid = 1'b1;
        #4;
        check("x64_in_ready", 64'(io64.in_ready), 64'd1);
        a64 = cyc;
        @(posedge clk);
        #1;
        io64.in_valid = 1'b0;
        io64.src1     = '0;
        io64.src2     = '0;
        n64 = 0;
        @(negedge clk);
        #2;
        while (!io64.out_valid && n64 < 200) begin
            @(negedge clk);
            #2;
            n64++;
        end
        check("x64_latency", 64'(cyc - a64), 64'd65);
        check("x64_res", io64.res, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout reached want finish");
        $fatal(1, "watchdog");
    end
endmodule
